hh_blit_scheduler: RTL

Sequencing controller for the game's frame RAM and hard-hat sprite ROMs. It queues per-slot hard-hat redraw requests (steady/ready/hit) from game logic and arbitrates them round-robin. It blits the selected 30x20 sprite into the frame RAM at the slot's fixed origin, and interleaves a periodic full-screen copy of frame RAM to the VGA adapter. It owns the frame RAM's single address port; game logic never addresses the RAM directly.

---
 rtl/hh_blit_scheduler.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/hh_blit_scheduler.sv
// Frame RAM sequencer: round-robin hard-hat sprite blits into frame RAM,
// interleaved with periodic full-screen copies of frame RAM to the VGA adapter.
module hh_blit_scheduler #(
    parameter int X_SCREEN_PIXELS = 160,
    parameter int Y_SCREEN_PIXELS = 120,
    parameter int HH_W            = 30,
    parameter int HH_H            = 20,
    parameter int REFRESH_PERIOD  = 1250000
) (
    input  logic        clk,
    input  logic        iResetn,
    input  logic        iEnable,
    input  logic [4:0]  iReq,
    input  logic [14:0] iKind,
    output logic [9:0]  oSpriteAddr,
    output logic [2:0]  oSpriteSel,
    output logic [14:0] oRamAddr,
    output logic        oRamWren,
    output logic [7:0]  oX,
    output logic [6:0]  oY,
    output logic        oPlot,
    output logic        oBusy,
    output logic        oBlitDone,
    output logic        oFrameDone
);
    localparam int          NSLOT    = 5;
    localparam int          TW       = $clog2(REFRESH_PERIOD + 1);
    localparam logic [9:0]  SPR_LAST = 10'(HH_W * HH_H - 1);
    localparam logic [14:0] PIX_LAST = 15'(X_SCREEN_PIXELS * Y_SCREEN_PIXELS - 1);
    localparam logic [14:0] ROW_STEP = 15'(X_SCREEN_PIXELS - HH_W + 1);
    localparam logic [4:0]  COL_LAST = 5'(HH_W - 1);
    localparam logic [7:0]  X_LAST   = 8'(X_SCREEN_PIXELS - 1);

    typedef enum logic [1:0] {IDLE, BLIT, REFRESH} state_t;

    function automatic logic [14:0] slotOrigin(input logic [2:0] slot);
        case (slot)
            3'd0:    return 15'(15 * X_SCREEN_PIXELS + 47);
            3'd1:    return 15'(31 * X_SCREEN_PIXELS + 97);
            3'd2:    return 15'(63 * X_SCREEN_PIXELS + 126);
            3'd3:    return 15'(82 * X_SCREEN_PIXELS + 67);
            default: return 15'(53 * X_SCREEN_PIXELS + 10);
        endcase
    endfunction

    function automatic logic [2:0] nextSlot(input logic [2:0] slot);
        return (slot == 3'd4) ? 3'd0 : slot + 3'd1;
    endfunction

    state_t        state;
    logic [4:0]    pending;
    logic [2:0]    kindArr [NSLOT];
    logic [2:0]    lastGrant;
    logic [2:0]    grantSlot;
    logic [2:0]    cand;
    logic          anyPending;
    logic          grantNow;
    logic [TW-1:0] timer;
    logic          refreshPending;
    logic          expiry;
    logic          issuing;
    logic [4:0]    col;
    logic [14:0]   wrPtr;
    logic [7:0]    px;
    logic [6:0]    py;

    // Set wins over the grant-cycle clear so a request landing on its own grant is not lost.
    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : gSlot
            logic       pendQ;
            logic [2:0] kindQ;
            logic [2:0] reqKind;
            assign reqKind     = iKind[3*gi +: 3];
            assign pending[gi] = pendQ;
            assign kindArr[gi] = kindQ;
            always_ff @(posedge clk or negedge iResetn) begin
                if (!iResetn) begin
                    pendQ <= 1'b0;
                    kindQ <= 3'b000;
                end else if (iReq[gi]) begin
                    pendQ <= 1'b1;
                    kindQ <= (reqKind == 3'b001 || reqKind == 3'b010 || reqKind == 3'b100)
                             ? reqKind : 3'b001;
                end else if (grantNow && grantSlot == 3'(gi)) begin
                    pendQ <= 1'b0;
                end
            end
        end
    endgenerate

    always_comb begin
        anyPending = 1'b0;
        grantSlot  = 3'd0;
        cand       = nextSlot(lastGrant);
        for (int k = 0; k < NSLOT; k++) begin
            if (!anyPending && pending[cand]) begin
                anyPending = 1'b1;
                grantSlot  = cand;
            end
            cand = nextSlot(cand);
        end
    end

    assign grantNow = (state == IDLE) && !refreshPending && anyPending;
    assign expiry   = iEnable && (timer == TW'(REFRESH_PERIOD - 1));

    // Expiries coalesce into a single flag; one landing on the entry edge re-arms it.
    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            timer          <= '0;
            refreshPending <= 1'b0;
        end else if (!iEnable) begin
            timer          <= '0;
            refreshPending <= 1'b0;
        end else begin
            timer <= expiry ? '0 : timer + TW'(1);
            if (expiry)
                refreshPending <= 1'b1;
            else if (state == IDLE)
                refreshPending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            state       <= IDLE;
            lastGrant   <= 3'd4;
            issuing     <= 1'b0;
            col         <= '0;
            wrPtr       <= '0;
            px          <= '0;
            py          <= '0;
            oSpriteAddr <= '0;
            oSpriteSel  <= '0;
            oRamAddr    <= '0;
            oRamWren    <= 1'b0;
            oX          <= '0;
            oY          <= '0;
            oPlot       <= 1'b0;
            oBusy       <= 1'b0;
            oBlitDone   <= 1'b0;
            oFrameDone  <= 1'b0;
        end else begin
            oBlitDone  <= 1'b0;
            oFrameDone <= 1'b0;
            case (state)
                IDLE: begin
                    oRamWren <= 1'b0;
                    oPlot    <= 1'b0;
                    if (refreshPending) begin
                        state    <= REFRESH;
                        issuing  <= 1'b1;
                        oBusy    <= 1'b1;
                        oRamAddr <= '0;
                        px       <= '0;
                        py       <= '0;
                    end else if (anyPending) begin
                        state       <= BLIT;
                        issuing     <= 1'b1;
                        oBusy       <= 1'b1;
                        oSpriteSel  <= kindArr[grantSlot];
                        lastGrant   <= grantSlot;
                        oSpriteAddr <= '0;
                        col         <= '0;
                        wrPtr       <= slotOrigin(grantSlot);
                    end
                end
                BLIT: begin
                    // Write lags the ROM address by one cycle to absorb ROM read latency.
                    oRamAddr  <= wrPtr;
                    oRamWren  <= issuing;
                    oBlitDone <= issuing && (oSpriteAddr == SPR_LAST);
                    if (!issuing) begin
                        state <= IDLE;
                        oBusy <= 1'b0;
                    end else if (oSpriteAddr == SPR_LAST) begin
                        issuing <= 1'b0;
                    end else begin
                        oSpriteAddr <= oSpriteAddr + 10'd1;
                        if (col == COL_LAST) begin
                            col   <= '0;
                            wrPtr <= wrPtr + ROW_STEP;
                        end else begin
                            col   <= col + 5'd1;
                            wrPtr <= wrPtr + 15'd1;
                        end
                    end
                end
                REFRESH: begin
                    oRamWren   <= 1'b0;
                    oX         <= px;
                    oY         <= py;
                    oPlot      <= issuing;
                    oFrameDone <= issuing && (oRamAddr == PIX_LAST);
                    if (!issuing) begin
                        state <= IDLE;
                        oBusy <= 1'b0;
                    end else if (oRamAddr == PIX_LAST) begin
                        issuing <= 1'b0;
                    end else begin
                        oRamAddr <= oRamAddr + 15'd1;
                        if (px == X_LAST) begin
                            px <= '0;
                            py <= py + 7'd1;
                        end else begin
                            px <= px + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
